// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction reads and data reads/writes share one memory port.
// Ties alternate between masters; a stalled transfer is aborted with an error after TIMEOUT cycles.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    // instruction side
    input  logic        i_stb,
    input  logic [23:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    // data side
    input  logic        d_stb,
    input  logic        d_we,
    input  logic [23:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    // memory side
    output logic        m_stb,
    output logic        m_we,
    output logic [23:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    // Abort fires in the cycle whose missing ack would bring the count up to TIMEOUT.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        m_stb_q, m_stb_d;
    logic        m_we_q, m_we_d;
    logic [23:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic        i_err_q, i_err_d, d_err_q, d_err_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_d_q, last_d_d;

    logic i_elig, d_elig;
    logic finish, abort;

    always_comb begin
        state_d   = state_q;
        m_stb_d   = m_stb_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        cnt_d     = cnt_q;
        last_d_d  = last_d_q;
        finish    = 1'b0;
        abort     = 1'b0;

        // A master whose ack is out this cycle is masked so it cannot be issued twice.
        i_elig = i_stb & ~i_ack_q;
        d_elig = d_stb & ~d_ack_q;

        unique case (state_q)
            StIdle: begin
                if (d_elig && (!i_elig || !last_d_q)) begin
                    state_d   = StBusyD;
                    m_stb_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    cnt_d     = 8'd0;
                    last_d_d  = 1'b1;
                end else if (i_elig) begin
                    state_d   = StBusyI;
                    m_stb_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = 32'd0;
                    cnt_d     = 8'd0;
                    last_d_d  = 1'b0;
                end
            end
            StBusyI, StBusyD: begin
                if (m_ack) begin
                    finish = 1'b1;
                end else if (cnt_q == TimeoutLast) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (finish || abort) begin
                    state_d = StIdle;
                    m_stb_d = 1'b0;
                    if (state_q == StBusyD) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = abort;
                        d_rdata_d = finish ? m_rdata : 32'd0;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_err_d   = abort;
                        i_rdata_d = finish ? m_rdata : 32'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            m_stb_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 24'd0;
            m_wdata_q <= 32'd0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            cnt_q     <= 8'd0;
            last_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_stb_q   <= m_stb_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
        end
    end

    assign m_stb   = m_stb_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_err   = i_err_q;
    assign d_err   = d_err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): single read, write with wait states,
// timeout boundary, tie alternation and asynchronous reset mid-transfer.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stb, i_ack, i_err;
    logic [23:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_stb, d_we, d_ack, d_err;
    logic [23:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        m_stb, m_we, m_ack;
    logic [23:0] m_addr;
    logic [31:0] m_wdata, m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_stb   (i_stb),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .d_stb   (d_stb),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        string order;
        rst = 1'b0; i_stb = 0; i_addr = 0; d_stb = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_rdata = 0; m_ack = 0;
        #1 rst = 1'b1;
        #2;
        check("rst_m_stb", 32'(m_stb), 0);
        check("rst_m_addr", 32'(m_addr), 0);
        check("rst_acks", {30'd0, i_ack, d_ack}, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        do_reset();

        // Single instruction read; m_ack held high from IDLE must be ignored there.
        i_stb = 1; i_addr = 24'hFFE000; m_rdata = 32'h12345678; m_ack = 1;
        @(negedge clk);
        check("rd_m_stb", 32'(m_stb), 1);
        check("rd_m_addr", 32'(m_addr), 32'hFFE000);
        check("rd_m_we", 32'(m_we), 0);
        check("rd_ack_early", 32'(i_ack), 0);
        @(negedge clk);
        check("rd_i_ack", 32'(i_ack), 1);
        check("rd_i_err", 32'(i_err), 0);
        check("rd_i_rdata", i_rdata, 32'h12345678);
        check("rd_m_stb_drop", 32'(m_stb), 0);
        i_stb = 0; m_ack = 0;
        @(negedge clk);
        check("rd_i_ack_pulse", 32'(i_ack), 0);

        // Data write with three wait states.
        d_stb = 1; d_we = 1; d_addr = 24'h000100; d_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("wr_m_stb", 32'(m_stb), 1);
            check("wr_m_we", 32'(m_we), 1);
            check("wr_m_addr", 32'(m_addr), 32'h000100);
            check("wr_m_wdata", m_wdata, 32'hDEADBEEF);
            check("wr_d_ack_wait", 32'(d_ack), 0);
            d_addr = 24'h777777; d_wdata = 32'h0;
            if (c == 4) begin
                m_ack = 1; m_rdata = 32'hCAFEF00D;
            end
        end
        @(negedge clk);
        check("wr_d_ack", 32'(d_ack), 1);
        check("wr_d_err", 32'(d_err), 0);
        check("wr_d_rdata", d_rdata, 32'hCAFEF00D);
        check("wr_i_rdata_hold", i_rdata, 32'h12345678);
        d_stb = 0; d_we = 0; m_ack = 0;
        @(negedge clk);
        check("wr_d_ack_pulse", 32'(d_ack), 0);

        // Timeout: no m_ack for four BUSY cycles.
        i_stb = 1; i_addr = 24'hABCDEF; m_rdata = 32'h55555555;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("to_m_stb", 32'(m_stb), 1);
            check("to_i_ack_wait", 32'(i_ack), 0);
        end
        @(negedge clk);
        check("to_m_stb_drop", 32'(m_stb), 0);
        check("to_i_ack", 32'(i_ack), 1);
        check("to_i_err", 32'(i_err), 1);
        check("to_i_rdata", i_rdata, 0);
        i_stb = 0;
        @(negedge clk);
        check("to_i_err_pulse", 32'(i_err), 0);

        // m_ack on the fourth BUSY cycle still completes normally.
        i_stb = 1; i_addr = 24'h000ABC;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("tob_m_stb", 32'(m_stb), 1);
            if (c == 4) begin
                m_ack = 1; m_rdata = 32'h0F0F0F0F;
            end
        end
        @(negedge clk);
        check("tob_i_ack", 32'(i_ack), 1);
        check("tob_i_err", 32'(i_err), 0);
        check("tob_i_rdata", i_rdata, 32'h0F0F0F0F);
        i_stb = 0; m_ack = 0;
        @(negedge clk);

        // Both requesting from reset: data wins the first tie, then strict alternation.
        do_reset();
        i_stb = 1; i_addr = 24'h000010; d_stb = 1; d_we = 0; d_addr = 24'h000020;
        m_ack = 1; m_rdata = 32'h11112222;
        order = "";
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("alt_no_double_ack", 32'(i_ack & d_ack), 0);
            if (c == 1) check("alt_first_addr", 32'(m_addr), 32'h000020);
            if (c == 3) check("alt_second_addr", 32'(m_addr), 32'h000010);
            if (d_ack) order = {order, "D"};
            if (i_ack) order = {order, "I"};
        end
        checks++;
        if (order != "DIDI") begin
            errors++;
            $display("FAIL alt_order: got %s expected DIDI", order);
        end
        i_stb = 0; d_stb = 0; m_ack = 0;
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of a data transfer.
        d_stb = 1; d_addr = 24'h000300;
        @(negedge clk);
        check("ar_m_stb_busy", 32'(m_stb), 1);
        #1 rst = 1'b1;
        #1;
        check("ar_m_stb_async", 32'(m_stb), 0);
        check("ar_m_addr_async", 32'(m_addr), 0);
        check("ar_d_ack", 32'(d_ack), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ar_reissue_stb", 32'(m_stb), 1);
        check("ar_reissue_addr", 32'(m_addr), 32'h000300);
        check("ar_no_ack", 32'(d_ack), 0);
        m_ack = 1; m_rdata = 32'h3C3C3C3C;
        @(negedge clk);
        check("ar_d_ack_done", 32'(d_ack), 1);
        check("ar_d_rdata", d_rdata, 32'h3C3C3C3C);
        d_stb = 0; m_ack = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of BUSY cycles without m_ack before the transfer is aborted (range 1..255).
REQ-002 SHALL have port clk, input, 1, the system clock; all state changes on posedge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have instruction-side ports: i_stb in 1 (read request), i_addr in 24 (byte address), i_rdata out 32, i_ack out 1, i_err out 1.
REQ-005 SHALL have data-side ports: d_stb in 1, d_we in 1 (1=write), d_addr in 24, d_wdata in 32, d_rdata out 32, d_ack out 1, d_err out 1.
REQ-006 SHALL have memory-side ports: m_stb out 1, m_we out 1, m_addr out 24, m_wdata out 32, m_rdata in 32, m_ack in 1.

Function
REQ-007 SHALL implement states IDLE, BUSY_I and BUSY_D.
REQ-008 Request eligibility: x_stb=1 and x_ack=0 in the same cycle; a requester is masked in the cycle its ack is asserted, so no double issue.
REQ-009 IDLE with exactly one eligible request: SHALL grant that requester at the next edge.
REQ-010 IDLE with both eligible: SHALL grant the requester not granted last; last-grant flag resets to "instruction", so data wins the first tie.
REQ-011 On grant: SHALL register m_addr and m_we (0 for instruction) from the winner, m_wdata=d_wdata for data and 0 for instruction, set m_stb=1, and enter BUSY_I or BUSY_D.
REQ-012 In BUSY: m_stb, m_we, m_addr and m_wdata SHALL stay stable until completion; x_stb and x_addr changes SHALL be ignored.
REQ-013 BUSY with m_ack=1: SHALL, at the next edge, drop m_stb, pulse the granted x_ack for exactly 1 cycle with x_err=0, load x_rdata=m_rdata (reads and writes alike), and return to IDLE.
REQ-014 Minimum latency: request sampled at edge N, m_stb=1 after N, m_ack in that cycle, x_ack=1 after edge N+1, giving 2 cycles.
REQ-015 x_rdata SHALL hold its value until that requester's next completion.
REQ-016 Timeout counter (8 bits): SHALL clear on grant and increment every BUSY cycle with m_ack=0.
REQ-017 When the counter equals TIMEOUT with m_ack=0: SHALL drop m_stb, pulse x_ack with x_err=1 and x_rdata=0, and return to IDLE.
REQ-018 When m_ack=1 in the cycle the counter equals TIMEOUT: SHALL complete normally (REQ-013).
REQ-019 m_ack in IDLE SHALL be ignored.
REQ-020 The non-granted requester SHALL wait with its ack held at 0; its request is served at the next IDLE arbitration.
REQ-021 i_ack and d_ack SHALL never be 1 in the same cycle; m_stb SHALL never be 1 in IDLE.

Reset
REQ-022 rst=1 SHALL immediately force: state IDLE, m_stb=0, m_we=0, m_addr=0, m_wdata=0, i_ack=d_ack=0, i_err=d_err=0, i_rdata=d_rdata=0, counter=0, last-grant=instruction.
REQ-023 rst during BUSY SHALL abort the transfer with no ack pulse; after release, pending requests are arbitrated afresh.

Verification
REQ-024 Single instruction read: i_stb=1, i_addr=FFE000, m_ack=1 on first m_stb cycle, m_rdata=12345678 -> m_addr=FFE000, m_we=0, i_ack one cycle with i_rdata=12345678, total 2 cycles.
REQ-025 Simultaneous requests: i_stb=d_stb=1 right after reset, held -> data served first, instruction next, then alternating D,I,D,I over 4 transfers, with no cycle having both acks set.
REQ-026 Data write: d_we=1, d_addr=000100, d_wdata=DEADBEEF, m_ack delayed 3 cycles -> m_* stable for 4 cycles, d_ack single pulse, d_err=0.
REQ-027 Timeout: TIMEOUT=4, m_ack never asserted -> m_stb drops after 4 BUSY cycles, i_ack=1 with i_err=1 and i_rdata=0; a second case with m_ack on cycle 4 gives i_err=0.
REQ-028 Async reset mid-BUSY_D: rst pulsed between clock edges -> m_stb=0 before the next edge, no d_ack; held d_stb is reissued after release.
